micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Parametrised microprogram sequencer: a single-block replacement for cascaded 4-bit sequencer slices.
//  Picks the next microaddress from four sources: uPC, address register, stack top, or direct input.
//  Adds a deeper stack with full/empty/error flags, a loop counter mode on the address register
//  and a synchronous stack clear. Sits between the microcode ROM address bus and the branch logic.
// PARAMETERS
//  WIDTH        12  microaddress width in bits (>=4)
//  STACK_DEPTH  4   number of stack entries (>=2)
// PORTS
//  clock      in   1            rising-edge system clock
//  reset      in   1            asynchronous, active-high reset
//  din        in   WIDTH        direct address / AR load data
//  sel        in   2            next-address source: 00 uPC, 01 AR, 10 stack top, 11 din
//  zero_n     in   1            0 forces yout to all zeros
//  cin        in   1            uPC increment enable / carry in
//  re_n       in   1            0 loads AR from din
//  dec        in   1            1 decrements AR (counter mode)
//  fe_n       in   1            0 enables a stack operation
//  pup        in   1            stack direction with fe_n=0: 1 push, 0 pop
//  stack_clr  in   1            synchronous stack clear
//  yout       out  WIDTH        next microaddress (combinational)
//  cout       out  1            carry out: cin & (yout == all ones)
//  ar_zero    out  1            AR == 0 (combinational)
//  full       out  1            count == STACK_DEPTH
//  empty      out  1            count == 0
//  stack_err  out  1            sticky overflow/underflow flag
// BEHAVIOUR
//  - Reset: pc, ar, count, stack entries and stack_err are all cleared to 0.
//    After reset, empty=1, full=0, ar_zero=1, and yout=0 for sel=00 or sel=10.
//  - yout: zero_n=0 gives 0. Otherwise mux(sel) with no latency.
//    The stack top is stack[count-1]; it reads 0 when empty.
//  - uPC: pc <= yout + cin each edge, modulo 2^WIDTH; all-ones + 1 wraps to 0 with cout=1.
//  - AR: re_n=0 gives ar <= din (takes priority over dec).
//    Else dec=1 and ar!=0 gives ar <= ar-1. Else ar holds, and it saturates at 0.
//  - Push (fe_n=0, pup=1): stack[count] <= pc (the pre-edge uPC), count+1.
//    In the same cycle, sel=10 still reads the old top.
//  - Pop (fe_n=0, pup=0): count-1. sel=10 in the same cycle returns the popped entry,
//    so return = sel 10 + pop.
//  - Push when full: write dropped, count unchanged, stack_err <= 1.
//  - Pop when empty: count unchanged, stack_err <= 1.
//  - stack_clr=1: count <= 0 and stack_err <= 0. It overrides any fe_n operation that cycle;
//    pc and ar update normally.
//  - stack_err clears only on reset or stack_clr.
//  - Reset asserted mid-cycle clears state immediately. There are no outputs pending across reset.
// STRUCTURE
//  - Package micro_seq_pkg holds SEL_PC/SEL_AR/SEL_STK/SEL_DIN localparams (2'b00..2'b11)
//    and a clog2 helper for the count width.
//  - Sub-module micro_stack(#WIDTH, DEPTH) owns the LIFO array, the 0..DEPTH count,
//    full/empty, top read and the error flag.
//  - The top level keeps pc, ar, the source mux, the zero gate and the carry logic.
// TESTING (WIDTH=12, STACK_DEPTH=4)
//  - Reset, then sel=00 and cin=1 for 3 clocks:
//    -> yout 000,001,002; all-ones pc with cin=1 gives cout=1, next yout 000.
//  - din=0x345, re_n=0 for one clock, then sel=01:
//    -> yout 0x345; zero_n=0 gives yout 0, and pc <= 0+cin.
//  - pc=0x010, push, jump via sel=11 to din=0x200, run 2 steps, then sel=10 + pop:
//    -> yout 0x010, empty=1.
//  - 4 pushes -> full=1; 5th push -> count 4, stack_err=1;
//    stack_clr -> empty=1, stack_err=0.
//  - Pop when empty -> stack_err=1, count stays 0, sel=10 yields 0.
//  - AR=3, dec=1 for 5 clocks -> ar 2,1,0,0,0; ar_zero goes high after the 3rd edge;
//    re_n=0 with dec=1 loads din.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// rtl/micro_seq_pkg.sv - shared source-select codes and width helper for the microprogram sequencer
package micro_seq_pkg;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_DIN = 2'b11;

  // Bits needed to hold values 0..n-1; callers pass DEPTH+1 to cover a full stack.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/micro_stack.sv
// rtl/micro_stack.sv - LIFO return-address stack with occupancy flags and sticky overflow/underflow error
module micro_stack
  import micro_seq_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] wdata,
  input  logic             op_en,
  input  logic             op_push,
  input  logic             clr,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int CW = clog2(DEPTH + 1);

  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign err   = err_q;

  // Top of stack is entry count-1; an empty stack reads as zero.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) top = mem_q[i];
    end
  end

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    mem_d   = mem_q;
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (op_en) begin
      if (op_push) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i)) mem_d[i] = wdata;
          end
          count_d = count_q + 1'b1;
        end
      end else if (empty) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - next-microaddress selection with uPC, loop-counting AR and subroutine stack
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sel,
  input  logic             zero_n,
  input  logic             cin,
  input  logic             re_n,
  input  logic             dec,
  input  logic             fe_n,
  input  logic             pup,
  input  logic             stack_clr,
  output logic [WIDTH-1:0] yout,
  output logic             cout,
  output logic             ar_zero,
  output logic             full,
  output logic             empty,
  output logic             stack_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ar_q, ar_d;
  logic [WIDTH-1:0] stk_top;
  logic [WIDTH-1:0] mux_y;

  micro_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock   (clock),
    .reset   (reset),
    .wdata   (pc_q),
    .op_en   (~fe_n),
    .op_push (pup),
    .clr     (stack_clr),
    .top     (stk_top),
    .full    (full),
    .empty   (empty),
    .err     (stack_err)
  );

  always_comb begin
    mux_y = '0;
    case (sel)
      SEL_PC:  mux_y = pc_q;
      SEL_AR:  mux_y = ar_q;
      SEL_STK: mux_y = stk_top;
      SEL_DIN: mux_y = din;
      default: mux_y = '0;
    endcase
  end

  assign yout    = zero_n ? mux_y : '0;
  assign cout    = cin & (&yout);
  assign ar_zero = (ar_q == '0);

  // uPC follows the selected address, so jumps and returns continue from their target.
  always_comb begin
    pc_d = yout + WIDTH'(cin);
    ar_d = ar_q;
    if (!re_n) begin
      ar_d = din;
    end else if (dec && !ar_zero) begin
      ar_d = ar_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      ar_q <= '0;
    end else begin
      pc_q <= pc_d;
      ar_q <= ar_d;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - scoreboard bench: directed and random stimulus against a queue-based reference model
module tb_micro_sequencer;

  logic        clock;
  logic        reset;
  logic [11:0] din;
  logic [1:0]  sel;
  logic        zero_n, cin, re_n, dec, fe_n, pup, stack_clr;
  logic [11:0] yout;
  logic        cout, ar_zero, full, empty, stack_err;

  micro_sequencer #(.WIDTH(12), .STACK_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .sel       (sel),
    .zero_n    (zero_n),
    .cin       (cin),
    .re_n      (re_n),
    .dec       (dec),
    .fe_n      (fe_n),
    .pup       (pup),
    .stack_clr (stack_clr),
    .yout      (yout),
    .cout      (cout),
    .ar_zero   (ar_zero),
    .full      (full),
    .empty     (empty),
    .stack_err (stack_err)
  );

  typedef struct {
    int y;
    int co;
    int arz;
    int fl;
    int em;
    int er;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_pc = 0;
  int   m_ar = 0;
  int   m_err = 0;
  int   m_stk[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("yout", int'(yout), e.y);
      chk("cout", int'(cout), e.co);
      chk("ar_zero", int'(ar_zero), e.arz);
      chk("full", int'(full), e.fl);
      chk("empty", int'(empty), e.em);
      chk("stack_err", int'(stack_err), e.er);
    end
  end

  // One cycle: drive after the rising edge, predict outputs, then advance the model to the next edge.
  task automatic step(input int rst_i, input int sel_i, input int din_i, input int zn_i,
                      input int cin_i, input int ren_i, input int dec_i, input int fen_i,
                      input int pup_i, input int clr_i);
    exp_t e;
    int   top, y, old_pc;
    @(posedge clock);
    #1;
    reset     = rst_i[0];
    sel       = sel_i[1:0];
    din       = din_i[11:0];
    zero_n    = zn_i[0];
    cin       = cin_i[0];
    re_n      = ren_i[0];
    dec       = dec_i[0];
    fe_n      = fen_i[0];
    pup       = pup_i[0];
    stack_clr = clr_i[0];
    if (rst_i != 0) begin
      m_pc = 0;
      m_ar = 0;
      m_err = 0;
      m_stk.delete();
    end
    top = (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 0;
    case (sel_i)
      0: y = m_pc;
      1: y = m_ar;
      2: y = top;
      default: y = din_i & 12'hFFF;
    endcase
    if (zn_i == 0) y = 0;
    e.y   = y;
    e.co  = (cin_i != 0 && y == 12'hFFF) ? 1 : 0;
    e.arz = (m_ar == 0) ? 1 : 0;
    e.fl  = (m_stk.size() == 4) ? 1 : 0;
    e.em  = (m_stk.size() == 0) ? 1 : 0;
    e.er  = m_err;
    exp_q.push_back(e);
    if (rst_i == 0) begin
      old_pc = m_pc;
      m_pc = (y + cin_i) % 4096;
      if (ren_i == 0) m_ar = din_i & 12'hFFF;
      else if (dec_i != 0 && m_ar != 0) m_ar = m_ar - 1;
      if (clr_i != 0) begin
        m_stk.delete();
        m_err = 0;
      end else if (fen_i == 0) begin
        if (pup_i != 0) begin
          if (m_stk.size() == 4) m_err = 1;
          else m_stk.push_back(old_pc);
        end else begin
          if (m_stk.size() == 0) m_err = 1;
          else void'(m_stk.pop_back());
        end
      end
    end
  endtask

  // Shorthand for common non-stack cycles: sel, din, cin.
  task automatic run(input int sel_i, input int din_i, input int cin_i);
    step(0, sel_i, din_i, 1, cin_i, 1, 0, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sel = 2'b00; din = '0; zero_n = 1'b1; cin = 1'b0;
    re_n = 1'b1; dec = 1'b0; fe_n = 1'b1; pup = 1'b0; stack_clr = 1'b0;

    step(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    step(1, 2, 0, 1, 0, 1, 0, 1, 0, 0);

    // Sequential counting and wrap from all ones.
    run(0, 0, 1); run(0, 0, 1); run(0, 0, 1);
    run(3, 12'hFFF, 0);
    run(0, 0, 1);
    run(0, 0, 0);

    // AR load, read, zero gate.
    step(0, 0, 12'h345, 1, 0, 0, 0, 1, 0, 0);
    run(1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    run(0, 0, 0);

    // Call and return.
    run(3, 12'h010, 0);
    step(0, 3, 12'h200, 1, 1, 1, 0, 0, 1, 0);
    run(0, 0, 1); run(0, 0, 1);
    step(0, 2, 0, 1, 1, 1, 0, 0, 0, 0);
    run(0, 0, 0);

    // Fill, overflow, clear.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    step(0, 2, 0, 1, 0, 1, 0, 0, 1, 1);
    run(2, 0, 0);

    // Underflow.
    step(0, 2, 0, 1, 0, 1, 0, 0, 0, 0);
    run(2, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 1, 0, 1);

    // Loop counter saturation and load priority over decrement.
    step(0, 1, 3, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 1, 1, 1, 0, 0);
    step(0, 1, 12'h0AB, 1, 0, 0, 1, 1, 0, 0);
    run(1, 0, 0);

    for (int n = 0; n < 400; n++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? 12'hFFF : int'($urandom_range(0, 4095));
      step(($urandom_range(0, 59) == 0) ? 1 : 0,
           int'($urandom_range(0, 3)), d,
           ($urandom_range(0, 7) == 0) ? 0 : 1,
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0) ? 0 : 1,
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    repeat (2) @(posedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
